fp_op_scheduler: RTL and testbench

- Command sequencer for the shared IEEE-754 single-precision arithmetic unit.
- Accepts 66-bit command frames {op[1:0], operand_a[31:0], operand_b[31:0]} from the UART receive path and buffers them in a small FIFO.
- Issues one operation at a time to the arithmetic unit using a start/done handshake, then captures the result.
- Presents the result to the display formatter with a valid/ready handshake.

---
 rtl/fp_sched_pkg.sv | 34 +++
 rtl/fps_cmd_fifo.sv | 57 +++++
 rtl/fp_op_scheduler.sv | 133 +++++++++++++
 tb/tb_fp_op_scheduler.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sched_pkg.sv
// Shared definitions for the FP operation scheduler: op and state encodings,
// command frame layout and the canned watchdog result.
package fp_sched_pkg;

   localparam int OP_W       = 2;
   localparam int DATA_W     = 32;
   localparam int CMD_W      = OP_W + 2 * DATA_W;
   localparam int CMD_OP_LSB = 2 * DATA_W;
   localparam int CMD_A_LSB  = DATA_W;
   localparam int CMD_B_LSB  = 0;

   localparam logic [DATA_W-1:0] FP_QNAN = 32'h7FC0_0000;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } fp_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      HOLD  = 2'b11
   } state_e;

   function automatic logic [CMD_W-1:0] pack_cmd(input logic [OP_W-1:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      return {op, a, b};
   endfunction

endpackage

// File: rtl/fps_cmd_fifo.sv
// Small power-of-two command FIFO with occupancy-based full/empty flags.
// Pushes when full and pops when empty are ignored.
module fps_cmd_fifo #(
   parameter int WIDTH = 66,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W  = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == OCC_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // NOTE: the storage array has no reset; only pointers and count decide
   // what is valid, and leaving it unreset lets it map onto plain flops/RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fp_op_scheduler.sv
// Command sequencer for the shared single-precision FP unit: FIFO-buffered
// commands, start/done issue, valid/ready result. Watchdog under FPS_TIMEOUT_EN.
module fp_op_scheduler
   import fp_sched_pkg::*;
#(
   parameter int CMD_DEPTH      = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CMD_W-1:0]  cmd_data,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   output logic [OP_W-1:0]   fpu_op,
   output logic [DATA_W-1:0] fpu_a,
   output logic [DATA_W-1:0] fpu_b,
   output logic              fpu_start,
   input  logic              fpu_done,
   input  logic [DATA_W-1:0] fpu_result,
   output logic [DATA_W-1:0] res_data,
   output logic [OP_W-1:0]   res_op,
   output logic              res_err,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  op_count
);

   if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1)
   begin : g_bad_params
      $error("fp_op_scheduler: CMD_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
   end

   state_e           state;
   logic [CMD_W-1:0] head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;

   assign fifo_push = cmd_valid && !fifo_full;
   assign fifo_pop  = (state == IDLE) && !fifo_empty;
   assign cmd_ready = !fifo_full;
   assign busy      = (state != IDLE) || !fifo_empty;

   fps_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (fifo_push),
      .wr_data (cmd_data),
      .pop     (fifo_pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

`ifdef FPS_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
`else
   assign res_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         fpu_op    <= '0;
         fpu_a     <= '0;
         fpu_b     <= '0;
         fpu_start <= 1'b0;
         res_data  <= '0;
         res_op    <= '0;
         res_valid <= 1'b0;
         op_count  <= '0;
`ifdef FPS_TIMEOUT_EN
         res_err   <= 1'b0;
         wd_cnt    <= '0;
`endif
      end else begin
         fpu_start <= 1'b0;
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  fpu_op    <= head[CMD_OP_LSB +: OP_W];
                  fpu_a     <= head[CMD_A_LSB  +: DATA_W];
                  fpu_b     <= head[CMD_B_LSB  +: DATA_W];
                  fpu_start <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
`ifdef FPS_TIMEOUT_EN
               wd_cnt <= '0;
`endif
            end
            WAIT: begin
               // A done in the watchdog's final cycle still takes priority.
               if (fpu_done) begin
                  res_data  <= fpu_result;
                  res_op    <= fpu_op;
                  res_valid <= 1'b1;
                  state     <= HOLD;
`ifdef FPS_TIMEOUT_EN
                  res_err   <= 1'b0;
               end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                  res_data  <= FP_QNAN;
                  res_op    <= fpu_op;
                  res_err   <= 1'b1;
                  res_valid <= 1'b1;
                  state     <= HOLD;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
`endif
               end
            end
            HOLD: begin
               if (res_valid && res_ready) begin
                  res_valid <= 1'b0;
                  op_count  <= op_count + 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_op_scheduler.sv
// Self-checking bench for fp_op_scheduler: directed table, multi-cycle corner
// sequences and randomized traffic against a queue-based scoreboard.
module tb_fp_op_scheduler;
   import fp_sched_pkg::*;

   localparam int DEPTH = 2;
   localparam int TO    = 16;
   localparam int CW    = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [65:0]   cmd_data;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    fpu_op;
   logic [31:0]   fpu_a;
   logic [31:0]   fpu_b;
   logic          fpu_start;
   logic          fpu_done;
   logic [31:0]   fpu_result;
   logic [31:0]   res_data;
   logic [1:0]    res_op;
   logic          res_err;
   logic          res_valid;
   logic          res_ready;
   logic          busy;
   logic [CW-1:0] op_count;

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   fp_op_scheduler #(
      .CMD_DEPTH      (DEPTH),
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_data   (cmd_data),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .fpu_op     (fpu_op),
      .fpu_a      (fpu_a),
      .fpu_b      (fpu_b),
      .fpu_start  (fpu_start),
      .fpu_done   (fpu_done),
      .fpu_result (fpu_result),
      .res_data   (res_data),
      .res_op     (res_op),
      .res_err    (res_err),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .busy       (busy),
      .op_count   (op_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Arithmetic-unit model: exact IEEE results for the directed operands,
   // an operand hash for everything else (the scheduler only forwards it).
   function automatic logic [31:0] fpu_model(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      case ({op, a, b})
         {2'b10, 32'h40000000, 32'h40400000}: return 32'h40C00000;
         {2'b10, 32'h3F000000, 32'h40800000}: return 32'h40000000;
         {2'b10, 32'h3F000000, 32'h3F000000}: return 32'h3E800000;
         {2'b10, 32'hBF800000, 32'h40000000}: return 32'hC0000000;
         {2'b00, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
         {2'b01, 32'h40400000, 32'h3F800000}: return 32'h40000000;
         {2'b11, 32'h40C00000, 32'h40000000}: return 32'h40400000;
         {2'b00, 32'h3FC00000, 32'h40200000}: return 32'h40800000;
         {2'b01, 32'h3F800000, 32'h3F800000}: return 32'h00000000;
         {2'b11, 32'h3F800000, 32'h40800000}: return 32'h3E800000;
         {2'b00, 32'h7F800000, 32'h3F800000}: return 32'h7F800000;
         default: return a ^ {b[15:0], b[31:16]} ^ {30'd0, op} ^ 32'h5A5A_0000;
      endcase
   endfunction

   // ---------------- arithmetic-unit responder ----------------
   logic        auto_done = 1'b0, man_done = 1'b0;
   logic [31:0] auto_res = '0, man_res = '0;
   bit          fpu_auto = 1'b1;
   bit          rand_lat = 1'b0;
   int          fpu_lat  = 3;
   int          resp_lat;
   logic [31:0] resp_val;
   int          done_cyc = -1;

   assign fpu_done   = auto_done | man_done;
   assign fpu_result = man_done ? man_res : auto_res;

   initial forever begin
      @(negedge clk);
      if (rst_n && fpu_start && fpu_auto) begin
         resp_lat = rand_lat ? int'($urandom_range(1, 6)) : fpu_lat;
         resp_val = fpu_model(fpu_op, fpu_a, fpu_b);
         repeat (resp_lat) @(posedge clk);
         #1;
         auto_done = 1'b1;
         auto_res  = resp_val;
         done_cyc  = cyc;
         @(posedge clk);
         #1;
         auto_done = 1'b0;
      end
   end

   // ---------------- scoreboard / monitor ----------------
   typedef struct { logic [1:0] op; logic [31:0] a; logic [31:0] b; } cmd_t;
   typedef struct { logic [1:0] op; logic [31:0] res; logic err; } exp_t;

   cmd_t        cmd_q[$];
   exp_t        res_q[$];
   logic [31:0] hs_data_q[$];
   cmd_t        mon_c;
   exp_t        mon_e;
   logic [CW-1:0] exp_count = '0;
   bit          expect_timeout = 1'b0;
   int          n_starts = 0, start_cyc = -1, n_rv = 0, rv_cyc = -1;
   int          hs_count = 0, hs_cyc = -1, push_cyc = -1;
   logic        prev_valid = 1'b0, prev_hs = 1'b0, prev_start = 1'b0, prev_err = 1'b0;
   logic [31:0] prev_data = '0;
   logic [1:0]  prev_op = '0;

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         prev_valid = 1'b0;
         prev_hs    = 1'b0;
         prev_start = 1'b0;
      end else begin
         if (fpu_start) begin
            check("start_single_cycle", prev_start, 0);
            n_starts++;
            start_cyc = cyc;
            if (cmd_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL start_unexpected: fpu_start with no command pending (cycle %0d)", cyc);
            end else begin
               mon_c = cmd_q.pop_front();
               check("start_op", fpu_op, mon_c.op);
               check("start_a", fpu_a, mon_c.a);
               check("start_b", fpu_b, mon_c.b);
               mon_e.op  = mon_c.op;
               mon_e.res = expect_timeout ? 32'h7FC00000 : fpu_model(mon_c.op, mon_c.a, mon_c.b);
               mon_e.err = expect_timeout;
               res_q.push_back(mon_e);
            end
         end
         if (res_valid && prev_valid && !prev_hs) begin
            check("hold_res_data", res_data, prev_data);
            check("hold_res_op", res_op, prev_op);
            check("hold_res_err", res_err, prev_err);
         end
         if (res_valid && !prev_valid) begin
            n_rv++;
            rv_cyc = cyc;
         end
         if (res_valid && res_ready) begin
            if (res_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL result_unexpected: res handshake with nothing issued (cycle %0d)", cyc);
            end else begin
               mon_e = res_q.pop_front();
               check("res_data", res_data, mon_e.res);
               check("res_op", res_op, mon_e.op);
               check("res_err", res_err, mon_e.err);
            end
            check("op_count_at_hs", op_count, exp_count);
            exp_count++;
            hs_count++;
            hs_cyc = cyc;
            hs_data_q.push_back(res_data);
         end
         prev_valid = res_valid;
         prev_hs    = res_valid && res_ready;
         prev_start = fpu_start;
         prev_data  = res_data;
         prev_op    = res_op;
         prev_err   = res_err;
      end
   end

   // ---------------- driver helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bit   accepted = 1'b0;
      int   guard = 0;
      cmd_t c;
      cmd_data  = pack_cmd(op, a, b);
      cmd_valid = 1'b1;
      while (!accepted && guard < 500) begin
         @(negedge clk);
         if (cmd_ready) begin
            accepted = 1'b1;
            c.op = op; c.a = a; c.b = b;
            cmd_q.push_back(c);
            push_cyc = cyc;
         end
         @(posedge clk);
         #1;
         guard++;
      end
      cmd_valid = 1'b0;
      cmd_data  = '0;
      check("push_accepted", accepted, 1);
   endtask

   task automatic wait_hs(input int target, input string name);
      int g = 0;
      while (hs_count < target && g < 300) begin tick(1); g++; end
      check(name, hs_count, target);
   endtask

   task automatic wait_starts(input int target, input string name);
      int g = 0;
      while (n_starts < target && g < 300) begin tick(1); g++; end
      check(name, n_starts, target);
   endtask

   task automatic wait_res_valid(input string name);
      int g = 0;
      while (!res_valid && g < 300) begin tick(1); g++; end
      check(name, res_valid, 1);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_cmd_ready"}, cmd_ready, 1);
      check({tag, "_fpu_start"}, fpu_start, 0);
      check({tag, "_fpu_op"},    fpu_op,    0);
      check({tag, "_fpu_a"},     fpu_a,     0);
      check({tag, "_fpu_b"},     fpu_b,     0);
      check({tag, "_res_valid"}, res_valid, 0);
      check({tag, "_res_data"},  res_data,  0);
      check({tag, "_res_op"},    res_op,    0);
      check({tag, "_res_err"},   res_err,   0);
      check({tag, "_busy"},      busy,      0);
      check({tag, "_op_count"},  op_count,  0);
   endtask

   typedef struct { logic [1:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp_res; } vec_t;
   vec_t vecs[6];

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "global timeout");
   end

   initial begin
      int b, s0, s1, r0;
      vecs[0] = '{OP_ADD, 32'h3FC00000, 32'h40200000, 32'h40800000};
      vecs[1] = '{OP_SUB, 32'h3F800000, 32'h3F800000, 32'h00000000};
      vecs[2] = '{OP_DIV, 32'h40C00000, 32'h40000000, 32'h40400000};
      vecs[3] = '{OP_DIV, 32'h3F800000, 32'h40800000, 32'h3E800000};
      vecs[4] = '{OP_MUL, 32'hBF800000, 32'h40000000, 32'hC0000000};
      vecs[5] = '{OP_ADD, 32'h7F800000, 32'h3F800000, 32'h7F800000};

      cmd_valid = 1'b0;
      cmd_data  = '0;
      res_ready = 1'b0;
      rst_n     = 1'b0;
      tick(3);
      check_reset("reset");
      rst_n = 1'b1;
      tick(2);
      check("idle_cmd_ready", cmd_ready, 1);
      check("idle_busy", busy, 0);

      // Single op 2.0 * 3.0 with latency checks
      res_ready = 1'b1;
      push_cmd(OP_MUL, 32'h40000000, 32'h40400000);
      wait_starts(1, "single_started");
      check("single_push_to_start", start_cyc, push_cyc + 2);
      wait_hs(1, "single_completed");
      check("single_done_to_valid", rv_cyc, done_cyc + 1);
      check("single_res_data", hs_data_q[hs_data_q.size() - 1], 32'h40C00000);
      check("single_op_count", op_count, 1);

      // Directed table
      for (int i = 0; i < 6; i++) begin
         b = hs_count;
         push_cmd(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_hs(b + 1, "tbl_completed");
         check("tbl_res_data", hs_data_q[hs_data_q.size() - 1], vecs[i].exp_res);
         check("tbl_op_count", op_count, exp_count);
      end

      // Back-to-back: fill the FIFO while the first op sits in WAIT
      fpu_lat = 6;
      b  = hs_data_q.size();
      s0 = n_starts;
      push_cmd(OP_MUL, 32'h3F000000, 32'h40800000);
      wait_starts(s0 + 1, "b2b_first_started");
      push_cmd(OP_MUL, 32'h3F000000, 32'h3F000000);
      push_cmd(OP_MUL, 32'hBF800000, 32'h40000000);
      @(negedge clk);
      check("b2b_full_cmd_ready", cmd_ready, 0);
      check("b2b_busy", busy, 1);
      @(posedge clk);
      #1;
      wait_hs(hs_count + 3, "b2b_completed");
      check("b2b_res0", hs_data_q[b],     32'h40000000);
      check("b2b_res1", hs_data_q[b + 1], 32'h3E800000);
      check("b2b_res2", hs_data_q[b + 2], 32'hC0000000);
      fpu_lat = 3;

      // Spurious done while IDLE
      tick(2);
      r0 = n_rv;
      s0 = n_starts;
      man_res  = 32'hDEADBEEF;
      man_done = 1'b1;
      tick(1);
      man_done = 1'b0;
      tick(2);
      check("idle_spur_res_valid", res_valid, 0);
      check("idle_spur_no_rise", n_rv, r0);
      check("idle_spur_no_start", n_starts, s0);
      check("idle_spur_res_data", res_data, 32'hC0000000);
      check("idle_spur_busy", busy, 0);

      // Backpressure for 10 cycles with a spurious done inside HOLD
      res_ready = 1'b0;
      b  = hs_count;
      s0 = n_starts;
      push_cmd(OP_ADD, 32'h3F800000, 32'h3F800000);
      push_cmd(OP_SUB, 32'h40400000, 32'h3F800000);
      wait_res_valid("bp_res_valid");
      s1 = n_starts;
      check("bp_one_started", s1, s0 + 1);
      tick(5);
      man_res  = 32'h12345678;
      man_done = 1'b1;
      tick(1);
      man_done = 1'b0;
      tick(4);
      check("bp_no_start_in_hold", n_starts, s1);
      check("bp_still_valid", res_valid, 1);
      check("bp_res_data", res_data, 32'h40000000);
      check("bp_res_op", res_op, OP_ADD);
      res_ready = 1'b1;
      wait_hs(b + 1, "bp_first_hs");
      wait_starts(s1 + 1, "bp_second_started");
      check("bp_hs_to_start", start_cyc, hs_cyc + 2);
      wait_hs(b + 2, "bp_second_hs");

      // Reset in the middle of WAIT, then a late done
      fpu_lat = 8;
      s0 = n_starts;
      push_cmd(OP_MUL, 32'h40000000, 32'h40400000);
      wait_starts(s0 + 1, "rst_started");
      tick(2);
      check("rst_busy_in_wait", busy, 1);
      rst_n = 1'b0;
      #1;
      check_reset("midwait_reset");
      cmd_q.delete();
      res_q.delete();
      exp_count = '0;
      tick(1);
      rst_n = 1'b1;
      r0 = n_rv;
      s0 = n_starts;
      tick(10);
      check("late_done_no_valid", n_rv, r0);
      check("late_done_res_valid", res_valid, 0);
      check("late_done_no_start", n_starts, s0);
      check("late_done_busy", busy, 0);
      check("late_done_op_count", op_count, 0);
      fpu_lat = 3;

`ifdef FPS_TIMEOUT_EN
      // Watchdog: the unit never answers
      fpu_auto       = 1'b0;
      expect_timeout = 1'b1;
      b  = hs_count;
      s0 = n_starts;
      push_cmd(OP_DIV, 32'h3F800000, 32'h00000000);
      wait_starts(s0 + 1, "to_started");
      wait_res_valid("to_res_valid");
      check("to_latency", rv_cyc, start_cyc + 1 + TO);
      check("to_res_data", res_data, 32'h7FC00000);
      check("to_res_err", res_err, 1);
      check("to_res_op", res_op, OP_DIV);
      wait_hs(b + 1, "to_hs");
      expect_timeout = 1'b0;
      fpu_auto       = 1'b1;
`endif

      // Randomized traffic: random gaps, latencies and res_ready
      rand_lat = 1'b1;
      b = hs_count;
      fork
         begin
            for (int i = 0; i < 30; i++) begin
               tick($urandom_range(0, 3));
               push_cmd(2'($urandom_range(0, 3)), $urandom, $urandom);
            end
         end
         begin
            int g = 0;
            while (hs_count < b + 30 && g < 5000) begin
               tick(1);
               res_ready = ($urandom_range(0, 3) != 0);
               g++;
            end
            res_ready = 1'b1;
         end
      join
      check("rand_all_results", hs_count, b + 30);
      tick(3);
      check("rand_end_busy", busy, 0);
      check("rand_end_cmd_ready", cmd_ready, 1);
      check("rand_end_op_count", op_count, exp_count);
      check("rand_end_res_q_empty", res_q.size(), 0);
      check("rand_end_cmd_q_empty", cmd_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
